iterative_shift_unit: RTL and testbench

- Multi-cycle shift/rotate execution unit for the RV32I core, covering SLL/SLLI, SRL/SRLI and SRA/SRAI, plus a rotate-left mode reserved for future extensions.
- Generalises the core's single-cycle ALU shift. Adds parametrised width, a configurable number of bits shifted per cycle, and a start/done handshake so the core can stall on it.
- Sits beside the ALU. Fed by the mux_a (operand) and mux_b (shift amount) outputs; the result returns to the register-file write-back mux.

---
 rtl/iterative_shift_unit.sv | 74 +++++++
 tb/tb_iterative_shift_unit.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/iterative_shift_unit.sv
// iterative_shift_unit: multi-cycle SLL/SRL/SRA/ROL unit with start/done handshake
module iterative_shift_unit #(
  parameter int XLEN = 32,
  parameter int SHAMT_W = 5,
  parameter int STEP = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [1:0]         op,
  input  logic [XLEN-1:0]    operand,
  input  logic [SHAMT_W-1:0] shamt,
  output logic               ready,
  output logic               busy,
  output logic               done,
  output logic [XLEN-1:0]    result
);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  localparam logic [SHAMT_W:0] STEP_C = (SHAMT_W+1)'(STEP);
  localparam logic [SHAMT_W:0] XLEN_C = (SHAMT_W+1)'(XLEN);
  state_t state, state_n;
  logic [XLEN-1:0] acc, acc_n, shifted, result_n;
  logic [SHAMT_W:0] rem, rem_n, n;
  logic [1:0] op_q, op_n;
  // bits moved this cycle and the accumulator after one step of the latched op
  always_comb begin
    n = rem < STEP_C ? rem : STEP_C;
    shifted = op_q == 2'b00 ? acc << n :
              op_q == 2'b01 ? acc >> n :
              op_q == 2'b11 ? $unsigned($signed(acc) >>> n) :
              (acc << n) | (acc >> (XLEN_C - n));
  end
  // next state; result is loaded only on entry to DONE so it holds otherwise
  always_comb begin
    state_n = state;
    acc_n = acc;
    rem_n = rem;
    op_n = op_q;
    result_n = result;
    if (state == IDLE && start) begin
      acc_n = operand;
      op_n = op;
      rem_n = {1'b0, shamt};
      state_n = shamt == '0 ? DONE : SHIFT;
      result_n = shamt == '0 ? operand : result;
    end else if (state == SHIFT) begin
      acc_n = shifted;
      rem_n = rem - n;
      state_n = rem == n ? DONE : SHIFT;
      result_n = rem == n ? shifted : result;
    end else if (state == DONE) begin
      state_n = IDLE;
    end
  end
  // state and datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      acc <= '0;
      rem <= '0;
      op_q <= '0;
      result <= '0;
    end else begin
      state <= state_n;
      acc <= acc_n;
      rem <= rem_n;
      op_q <= op_n;
      result <= result_n;
    end
  end
  assign ready = state == IDLE;
  assign busy = !ready;
  assign done = state == DONE;
endmodule

// File: tb/tb_iterative_shift_unit.sv
// tb_iterative_shift_unit: random and directed checks of two unit instances against a reference model
module tb_iterative_shift_unit;
  localparam logic [1:0] SLL = 2'b00, SRL = 2'b01, SRA = 2'b11, ROL = 2'b10;
  logic clk = 0, reset = 1;
  logic [1:0] start = '0, op = '0;
  logic [31:0] operand = '0;
  logic [4:0] shamt = '0;
  logic [1:0] ready, busy, done;
  logic [31:0] result [2];
  int vectors = 0, errors = 0;
  int steps [2] = '{1, 4};
  int cnt [2] = '{0, 0};
  logic [31:0] pend [2] = '{32'h0, 32'h0};
  logic [31:0] exp_res [2] = '{32'h0, 32'h0};

  iterative_shift_unit #(.XLEN(32), .SHAMT_W(5), .STEP(1)) u0 (
    .clk(clk), .reset(reset), .start(start[0]), .op(op), .operand(operand), .shamt(shamt),
    .ready(ready[0]), .busy(busy[0]), .done(done[0]), .result(result[0]));
  iterative_shift_unit #(.XLEN(32), .SHAMT_W(5), .STEP(4)) u1 (
    .clk(clk), .reset(reset), .start(start[1]), .op(op), .operand(operand), .shamt(shamt),
    .ready(ready[1]), .busy(busy[1]), .done(done[1]), .result(result[1]));

  always #5 clk = ~clk;

  function automatic logic [31:0] ref_shift(input logic [1:0] o, input logic [31:0] a, input int s);
    logic [63:0] t;
    t = {a, a} << s;
    case (o)
      SLL: return a << s;
      SRL: return a >> s;
      SRA: return $unsigned($signed(a) >>> s);
      default: return t[63:32];
    endcase
  endfunction

  // model: cnt counts remaining busy cycles; done is the last of them
  always @(posedge clk)
    for (int i = 0; i < 2; i++) begin
      automatic int c;
      automatic logic [31:0] r;
      c = cnt[i];
      r = exp_res[i];
      if (reset) begin
        c = 0;
        r = '0;
      end else if (c == 0) begin
        if (start[i]) begin
          c = (int'(shamt) + steps[i] - 1) / steps[i] + 1;
          pend[i] <= ref_shift(op, operand, int'(shamt));
          if (c == 1) r = ref_shift(op, operand, int'(shamt));
        end
      end else begin
        c--;
        if (c == 1) r = pend[i];
      end
      cnt[i] <= c;
      exp_res[i] <= r;
    end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    vectors++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, want);
    end
  endtask

  // compare {ready,busy,done,result} of both units against the model every cycle
  always @(negedge clk)
    for (int i = 0; i < 2; i++)
      check($sformatf("unit%0d outputs", i), {29'h0, ready[i], busy[i], done[i], result[i]},
            {29'h0, cnt[i] == 0, cnt[i] > 0, cnt[i] == 1, exp_res[i]});

  // one operation on unit u; inputs scrambled mid-flight, optional ignored start at cycle poke
  task automatic run(input int u, input logic [1:0] o, input logic [31:0] a, input logic [4:0] s,
                     input logic [31:0] want, input int lat, input int poke);
    int n;
    start[u] = 1'b1;
    op = o;
    operand = a;
    shamt = s;
    @(posedge clk); #1;
    n = 1;
    start[u] = 1'b0;
    while (!done[u] && n < 100) begin
      op = 2'($urandom);
      operand = $urandom;
      shamt = 5'($urandom);
      start[u] = n + 1 == poke;
      if (n + 1 == poke) operand = 32'hFFFF_FFFF;
      @(posedge clk); #1;
      n++;
      start[u] = 1'b0;
    end
    check($sformatf("latency u%0d op%0d sh%0d", u, o, s), 64'(n), 64'(lat));
    check($sformatf("result u%0d op%0d sh%0d", u, o, s), 64'(result[u]), 64'(want));
    @(posedge clk); #1;
    check($sformatf("held u%0d op%0d sh%0d", u, o, s), 64'(result[u]), 64'(want));
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("reset state", {61'h0, ready[0], busy[0], done[0]} | 64'(result[0]) << 3, 64'h4);
    reset = 0;
    run(0, SLL, 32'd20, 5'd4, 32'h0000_0140, 5, 0);
    run(0, SRA, 32'h8000_0000, 5'd31, 32'hFFFF_FFFF, 32, 0);
    run(0, SRL, 32'h8000_0000, 5'd31, 32'h0000_0001, 32, 0);
    run(0, SLL, 32'h1234_5678, 5'd0, 32'h1234_5678, 1, 0);
    run(0, SRL, 32'h1234_5678, 5'd8, 32'h0012_3456, 9, 0);
    run(0, ROL, 32'h8000_0001, 5'd1, 32'h0000_0003, 2, 0);
    run(1, ROL, 32'h8000_0001, 5'd9, 32'h0000_0300, 4, 0);
    run(0, SLL, 32'h0000_0ABC, 5'd10, 32'h002A_F000, 11, 3);
    run(1, SRA, 32'hF000_0000, 5'd31, 32'hFFFF_FFFF, 9, 0);
    start[0] = 1'b1;
    op = SRL;
    operand = 32'hDEAD_BEEF;
    shamt = 5'd16;
    @(posedge clk); #1;
    start[0] = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("abort by reset", {61'h0, ready[0], busy[0], done[0]} | 64'(result[0]) << 3, 64'h4);
    repeat (20) @(posedge clk);
    #1;
    run(0, SRL, 32'hDEAD_BEEF, 5'd16, 32'h0000_DEAD, 17, 0);
    repeat (3000) begin
      start = 2'($urandom);
      op = 2'($urandom);
      operand = $urandom;
      shamt = 5'($urandom);
      reset = $urandom_range(0, 99) == 0;
      @(posedge clk); #1;
    end
    start = '0;
    reset = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
